spi_slave_rx: RTL
=================

# spi_slave_rx

SPI slave receiver for mode 0/1 framing (CPOL 0, CPHA 1), the receiving end of the team's single-byte SPI master link. Oversamples SCL/SS/MOSI on the 50 MHz system clock, shifts in MSB-first bytes on SCL falling edges while SS is low, and presents each completed byte through a valid/ready holding register. Flags overruns and truncated frames. Sits between the FPGA pins and downstream byte consumers.

## Interface
- SYNC_STAGES, 2: synchronizer depth for SCL, SS, MOSI (min 2).
- DATA_W, 8: bits per frame.
- clk  in  1  50 MHz system clock.
- rst  in  1  reset; one clock, asynchronous, active-low.
- SCL  in  1  serial clock from master, asynchronous.
- SS  in  1  slave select, active-low, asynchronous.
- MOSI  in  1  serial data from master, asynchronous.
- rx_data  out  DATA_W  holding register, last completed byte.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts; transfer when rx_valid && rx_ready at clk edge.
- overrun  out  1  sticky: completed byte dropped because holding register full.
- frame_err  out  1  one-cycle pulse: SS deasserted mid-byte.
- MISO  out  1  only with SPI_SLAVE_MISO_EN.

## Operation
- Reset values: rx_data 0, rx_valid 0, overrun 0, frame_err 0, MISO 0; shift register 0, bit counter 0, state IDLE; synchronizer flops SCL 0, SS 1, MOSI 0.
- Edges detected on synchronized signals vs one-cycle-delayed copy.
- States: IDLE (SS high; SCL/MOSI ignored), SHIFT (SS low).
- IDLE -> SHIFT on SS falling edge: bit counter cleared, shift register cleared, overrun cleared.
- SHIFT, SCL falling edge: shift synchronized MOSI in at LSB (MSB-first on wire), counter+1.
- Counter reaches DATA_W: if holding empty, or being consumed this same cycle, load rx_data, rx_valid=1; else drop byte, set overrun. Counter wraps to 0, stay in SHIFT (multi-byte frames allowed).
- SHIFT -> IDLE on SS rising edge; if counter in 1..DATA_W-1, pulse frame_err, discard partial. Counter 0: no error.
- SS rising and SCL falling in same cycle: SS wins, SCL edge ignored.
- rx_valid cleared on handshake unless a new byte loads same cycle (then stays 1, no overrun).
- SCL rising edges ignored for reception.

## Timing
- SCL up to 250 kHz (≥100 clk per half-period); slave must work for half-period ≥ SYNC_STAGES+2 clk.
- Latency: pin edge of 8th SCL fall -> rx_valid high at SYNC_STAGES+1 clk edges (3 at default).
- MOSI passes same-depth synchronizer as SCL; stays aligned.
- frame_err asserted SYNC_STAGES+1 edges after SS pin rise, for exactly 1 cycle.
- rx_data stable while rx_valid high.

## Configuration
- SPI_SLAVE_MISO_EN defined: MISO port present; slave echoes the most recently completed byte (rx_data value at SS fall or at byte wrap), MSB first, updating MISO on each synchronized SCL rising edge (CPHA 1 leading edge); first bit driven on first rising edge; MISO 0 while IDLE.
- Not defined: no MISO port, no transmit shift register.

## Structure
- Package spi_slave_pkg: DATA_W default, bit-counter width ($clog2(DATA_W+1)), state enum {IDLE, SHIFT}.
- Sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs, reset value parameter; instantiated for SCL, SS, MOSI (MOSI uses level only).

## Test plan
- SS low, 8 SCL pulses at 250 kHz, MOSI 8'hAB (10101011) -> rx_valid at 3 clk after 8th fall, rx_data 8'hAB; rx_ready=1 clears rx_valid next edge.
- Two bytes 8'hAB, 8'h55 one frame, rx_ready held 0 -> rx_data stays 8'hAB, overrun=1 after second byte; next SS fall clears overrun.
- rx_ready asserted exactly in cycle second byte completes -> rx_data 8'h55, rx_valid stays 1, overrun 0.
- SS rises after 5 bits -> single frame_err pulse, rx_valid 0; next full frame 8'hC3 received correctly.
- SCL toggled with SS high -> no rx_valid; reset pulled low mid-frame after 4 bits -> all outputs to reset values, following frame 8'h0F received cleanly.
- SPI_SLAVE_MISO_EN: frame 8'hAB then frame 8'h12 -> MISO in second frame shifts 10101011 on SCL rising edges; 0 while SS high.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and defaults for the SPI slave receiver slice.
package spi_slave_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = $clog2(DATA_W_DEF + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall pulses
// taken against a one-cycle-delayed copy of the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Synchronizer chain plus delayed copy of its output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= {STAGES{RST_VAL}};
      prev_r <= RST_VAL;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign level = sync_r[STAGES-1];
  assign rise  = sync_r[STAGES-1] & ~prev_r;
  assign fall  = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver (CPOL 0, CPHA 1), MSB-first bytes into a valid/ready
// holding register. Define SPI_SLAVE_MISO_EN to echo the last byte on MISO.
module spi_slave_rx
  import spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCL,
  input  logic              SS,
  input  logic              MOSI,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              frame_err
`ifdef SPI_SLAVE_MISO_EN
  ,
  output logic              MISO
`endif
);

  localparam int CNT_W = cnt_width(DATA_W);

  logic              scl_lvl_s, scl_rise_s, scl_fall_s;
  logic              ss_lvl_s, ss_rise_s, ss_fall_s;
  logic              mosi_s, mosi_rise_s, mosi_fall_s;
  logic              unused_s;
  logic              wrap_s, load_s;
  logic [DATA_W-1:0] shift_next_s;

  state_e            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] shift_r;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_scl (
    .clk(clk), .rst(rst), .din(SCL),
    .level(scl_lvl_s), .rise(scl_rise_s), .fall(scl_fall_s)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .din(SS),
    .level(ss_lvl_s), .rise(ss_rise_s), .fall(ss_fall_s)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(MOSI),
    .level(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );

  assign unused_s = &{1'b0, scl_lvl_s, scl_rise_s, ss_lvl_s, mosi_rise_s, mosi_fall_s};

  // SS rising edge takes priority over a coincident SCL falling edge
  assign shift_next_s = {shift_r[DATA_W-2:0], mosi_s};
  assign wrap_s = (state_r == SHIFT) && !ss_rise_s && scl_fall_s &&
                  (cnt_r == CNT_W'(DATA_W - 1));
  assign load_s = wrap_s && (!rx_valid || rx_ready);

  // Receive FSM, bit counter, shift register and holding register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      shift_r   <= {DATA_W{1'b0}};
      rx_data   <= {DATA_W{1'b0}};
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (ss_fall_s) begin
            state_r <= SHIFT;
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {DATA_W{1'b0}};
            overrun <= 1'b0;
          end
        end
        SHIFT: begin
          if (ss_rise_s) begin
            state_r <= IDLE;
            if (cnt_r != {CNT_W{1'b0}}) begin
              frame_err <= 1'b1;
            end
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {DATA_W{1'b0}};
          end else if (scl_fall_s) begin
            shift_r <= shift_next_s;
            if (wrap_s) begin
              cnt_r <= {CNT_W{1'b0}};
              if (load_s) begin
                rx_data  <= shift_next_s;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef SPI_SLAVE_MISO_EN
  logic [DATA_W-1:0] tx_r;

  // Echo the most recently completed byte, one bit per SCL rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_r <= {DATA_W{1'b0}};
      MISO <= 1'b0;
    end else if (state_r == IDLE) begin
      MISO <= 1'b0;
      if (ss_fall_s) begin
        tx_r <= rx_data;
      end
    end else if (ss_rise_s) begin
      MISO <= 1'b0;
    end else if (wrap_s) begin
      tx_r <= load_s ? shift_next_s : rx_data;
    end else if (scl_rise_s) begin
      MISO <= tx_r[DATA_W-1];
      tx_r <= {tx_r[DATA_W-2:0], 1'b0};
    end
  end
`endif

endmodule
